// File: rtl/seq_shift_if.sv
// seq_shift_if: request/response handshake bundle for seq_shift_unit
interface seq_shift_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] operand1;
  logic [XLEN-1:0] operand2;
  logic [1:0]      op;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  modport master (
    output in_valid, operand1, operand2, op, out_ready,
    input  in_ready, out_valid, result
  );
  modport slave (
    input  in_valid, operand1, operand2, op, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/seq_shift_unit.sv
// seq_shift_unit: iterative SLL/SRL/SRA, one bit per clock, valid/ready on both sides.
// Define SEQ_SHIFT_ROT_EN to make op=10 a rotate right; otherwise op=10 behaves as SRL.
module seq_shift_unit #(
  parameter int XLEN = 32
) (
  input logic        clk,
  input logic        rst_n,
  seq_shift_if.slave s
);
  localparam int SHAMT_W = $clog2(XLEN);
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
  state_t              state_q, state_d;
  logic [XLEN-1:0]     acc_q, acc_d, step;
  logic [SHAMT_W-1:0]  count_q, count_d;
  logic [1:0]          op_q, op_d;
  logic                fill;
`ifdef SEQ_SHIFT_ROT_EN
  assign fill = (op_q == 2'b11) ? acc_q[XLEN-1] : (op_q == 2'b10) ? acc_q[0] : 1'b0;
`else
  assign fill = (op_q == 2'b11) & acc_q[XLEN-1];
`endif
  assign step = (op_q == 2'b00) ? {acc_q[XLEN-2:0], 1'b0} : {fill, acc_q[XLEN-1:1]};
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    op_d    = op_q;
    case (state_q)
      IDLE: if (s.in_valid) begin
        acc_d   = s.operand1;
        count_d = s.operand2[SHAMT_W-1:0];
        op_d    = s.op;
        state_d = (s.operand2[SHAMT_W-1:0] == '0) ? DONE : SHIFT;
      end
      SHIFT: begin
        acc_d   = step;
        count_d = count_q - 1'b1;
        state_d = (count_q == SHAMT_W'(1)) ? DONE : SHIFT;
      end
      DONE: state_d = s.out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      op_q    <= op_d;
    end
  end
  assign s.in_ready  = (state_q == IDLE);
  assign s.out_valid = (state_q == DONE);
  assign s.result    = (state_q == DONE) ? acc_q : '0;
endmodule

// File: tb/tb_seq_shift_unit.sv
// tb_seq_shift_unit: directed checks of seq_shift_unit handshake, latency and results
module tb_seq_shift_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   fails = 0;
  int   lat;
  seq_shift_if #(.XLEN(32)) bus ();
  seq_shift_unit #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .s(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    @(negedge clk);
    check({tag, "_in_ready_idle"}, {31'b0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1; bus.op = op; bus.operand1 = a; bus.operand2 = b; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_result"}, bus.result, exp);
    check({tag, "_in_ready_done"}, {31'b0, bus.in_ready}, 32'd0);
    @(posedge clk); #1;
    check({tag, "_out_valid_clr"}, {31'b0, bus.out_valid}, 32'd0);
  endtask
  initial begin
    bus.in_valid = 1'b0; bus.op = 2'b00; bus.operand1 = '0; bus.operand2 = '0; bus.out_ready = 1'b1;
    #3;
    check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_result", bus.result, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    run_op("sll1x4", 2'b00, 32'h0000_0001, 32'd4, 32'h0000_0010, 5);
    run_op("sra31", 2'b11, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 32);
    run_op("srl31", 2'b01, 32'h8000_0000, 32'd31, 32'h0000_0001, 32);
    run_op("shamt0", 2'b01, 32'hDEAD_BEEF, 32'h0000_0020, 32'hDEAD_BEEF, 1);
    run_op("sra_pos", 2'b11, 32'h4000_0000, 32'd2, 32'h1000_0000, 3);
    run_op("sll_ones", 2'b00, 32'hFFFF_FFFF, 32'd31, 32'h8000_0000, 32);
    run_op("sra_upper", 2'b11, 32'hF000_0F00, 32'hFFFF_FFE3, 32'hFE00_01E0, 4);
`ifdef SEQ_SHIFT_ROT_EN
    run_op("op10", 2'b10, 32'h0000_0001, 32'd1, 32'h8000_0000, 2);
`else
    run_op("op10", 2'b10, 32'h0000_0001, 32'd1, 32'h0000_0000, 2);
`endif
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = 2'b01; bus.operand1 = 32'h0000_00F0; bus.operand2 = 32'd4; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.operand1 = 32'h1234_5678; bus.operand2 = 32'd0; bus.op = 2'b00;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    check("bp_latency", 32'(lat), 32'd5);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_out_valid", {31'b0, bus.out_valid}, 32'd1);
      check("bp_result", bus.result, 32'h0000_000F);
      check("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("bp_release_out_valid", {31'b0, bus.out_valid}, 32'd0);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = 2'b00; bus.operand1 = 32'h0000_0001; bus.operand2 = 32'd20;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("mid_busy", {31'b0, bus.in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("mid_rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("mid_rst_result", bus.result, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    run_op("post_rst_srl", 2'b01, 32'h8000_0000, 32'd1, 32'h4000_0000, 2);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
